// File: rtl/bfm_rr_sched.sv
// Round-robin operand scheduler in front of a fixed-latency bfm.
// Two requesters compete for a single operand port (A_s/B_s). A tag
// pipeline of depth RES_LAT remembers which requester each issue belongs
// to, so that the bfm result can be routed back to that requester.
module bfm_rr_sched #(
    parameter int LENGTH  = 2000,
    parameter int RES_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             enable_i,
    input  logic             req0_valid_i,
    input  logic [7:0]       req0_a_i,
    input  logic [7:0]       req0_b_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [7:0]       req1_a_i,
    input  logic [7:0]       req1_b_i,
    output logic             req1_ready_o,
    output logic [7:0]       A_s,
    output logic [7:0]       B_s,
    output logic             issue_o,
    input  logic [7:0]       res_i,
    output logic             rsp0_valid_o,
    output logic             rsp1_valid_o,
    output logic [7:0]       rsp_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             done_o
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LENGTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   count_q;
    logic               last_q;        // 1: the most recent transfer served req1
    logic               gnt0;
    logic               gnt1;
    logic               run_ok;
    logic               xfer0;
    logic               xfer1;
    logic               xfer;
    logic               issue_id_p0;   // requester owning the op on A_s/B_s
    logic [RES_LAT-1:0] vld_p1;        // tag pipeline: valid bits
    logic [RES_LAT-1:0] id_p1;         // tag pipeline: requester ids
    logic               rsp_vld;
    logic               rsp_id;
    logic [7:0]         rsp_data_q;
    logic               pipe_empty;

    // Saturating transfer counter step: never exceeds LENGTH, never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= LEN_C) begin
            return LEN_C;
        end
        return v + CNT_W'(1);
    endfunction

    // Round-robin grant and handshake: on a tie the requester not served last wins.
    always_comb begin
        gnt0         = req0_valid_i & (~req1_valid_i | last_q);
        gnt1         = req1_valid_i & (~req0_valid_i | ~last_q);
        run_ok       = (state_q == RUN) & enable_i & (count_q < LEN_C);
        req0_ready_o = run_ok & gnt0;
        req1_ready_o = run_ok & gnt1;
        xfer0        = req0_valid_i & req0_ready_o;
        xfer1        = req1_valid_i & req1_ready_o;
        xfer         = xfer0 | xfer1;
    end

    // Next-state logic; reaching the transfer limit takes priority over a pause.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (count_q >= LEN_C) begin
                    state_d = DRAIN;
                end else if (!enable_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue stage: latch the granted operands, count transfers, move the pointer.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            A_s         <= '0;
            B_s         <= '0;
            issue_o     <= 1'b0;
            issue_id_p0 <= 1'b0;
            count_q     <= '0;
            last_q      <= 1'b1;
        end else begin
            issue_o <= xfer;
            if (xfer) begin
                A_s         <= xfer1 ? req1_a_i : req0_a_i;
                B_s         <= xfer1 ? req1_b_i : req0_b_i;
                issue_id_p0 <= xfer1;
                last_q      <= xfer1;
                count_q     <= sat_inc(count_q);
            end
        end
    end

    // Tag pipeline: advances every cycle in every state so in-flight results drain.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            vld_p1 <= '0;
            id_p1  <= '0;
        end else begin
            vld_p1[0] <= issue_o;
            id_p1[0]  <= issue_id_p0;
            for (int i = 1; i < RES_LAT; i++) begin
                vld_p1[i] <= vld_p1[i-1];
                id_p1[i]  <= id_p1[i-1];
            end
        end
    end

    // Response routing: the tail of the tag pipeline lines up with res_i.
    always_comb begin
        rsp_vld      = vld_p1[RES_LAT-1];
        rsp_id       = id_p1[RES_LAT-1];
        rsp0_valid_o = rsp_vld & ~rsp_id;
        rsp1_valid_o = rsp_vld & rsp_id;
        rsp_data_o   = rsp_vld ? res_i : rsp_data_q;
        pipe_empty   = ~issue_o & ~(|vld_p1);
        count_o      = count_q;
        done_o       = (state_q == DONE);
    end

    // Hold the last delivered result while no response is valid.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rsp_data_q <= '0;
        end else if (rsp_vld) begin
            rsp_data_q <= res_i;
        end
    end

endmodule

// File: tb/tb_bfm_rr_sched.sv
// Bench for bfm_rr_sched: three instances (long run, LENGTH=4, LENGTH=0)
// share one stimulus; the long-run instance is followed by a transaction-level
// reference model every cycle.
module tb_bfm_rr_sched;

    localparam int M_LEN = 2000;
    localparam int M_LAT = 3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       v0;
    logic       v1;
    logic [7:0] a0;
    logic [7:0] b0;
    logic [7:0] a1;
    logic [7:0] b1;
    logic [7:0] res;

    logic        m_rdy0, m_rdy1, m_iss, m_rsp0, m_rsp1, m_done;
    logic [7:0]  m_a_s, m_b_s, m_rdata;
    logic [15:0] m_cnt;
    logic        l_rdy0, l_rdy1, l_iss, l_rsp0, l_rsp1, l_done;
    logic [7:0]  l_a_s, l_b_s, l_rdata;
    logic [7:0]  l_cnt;
    logic        z_rdy0, z_rdy1, z_iss, z_rsp0, z_rsp1, z_done;
    logic [7:0]  z_a_s, z_b_s, z_rdata;
    logic [3:0]  z_cnt;

    int n_chk;
    int n_fail;
    int z_iss_cnt;

    bfm_rr_sched #(.LENGTH(M_LEN), .RES_LAT(M_LAT), .CNT_W(16)) u_main (
        .clk_i(clk), .reset_n_i(rst_n), .enable_i(en),
        .req0_valid_i(v0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(m_rdy0),
        .req1_valid_i(v1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(m_rdy1),
        .A_s(m_a_s), .B_s(m_b_s), .issue_o(m_iss), .res_i(res),
        .rsp0_valid_o(m_rsp0), .rsp1_valid_o(m_rsp1), .rsp_data_o(m_rdata),
        .count_o(m_cnt), .done_o(m_done)
    );

    bfm_rr_sched #(.LENGTH(4), .RES_LAT(2), .CNT_W(8)) u_lim (
        .clk_i(clk), .reset_n_i(rst_n), .enable_i(en),
        .req0_valid_i(v0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(l_rdy0),
        .req1_valid_i(v1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(l_rdy1),
        .A_s(l_a_s), .B_s(l_b_s), .issue_o(l_iss), .res_i(res),
        .rsp0_valid_o(l_rsp0), .rsp1_valid_o(l_rsp1), .rsp_data_o(l_rdata),
        .count_o(l_cnt), .done_o(l_done)
    );

    bfm_rr_sched #(.LENGTH(0), .RES_LAT(1), .CNT_W(4)) u_zero (
        .clk_i(clk), .reset_n_i(rst_n), .enable_i(en),
        .req0_valid_i(v0), .req0_a_i(a0), .req0_b_i(b0), .req0_ready_o(z_rdy0),
        .req1_valid_i(v1), .req1_a_i(a1), .req1_b_i(b1), .req1_ready_o(z_rdy1),
        .A_s(z_a_s), .B_s(z_b_s), .issue_o(z_iss), .res_i(res),
        .rsp0_valid_o(z_rsp0), .rsp1_valid_o(z_rsp1), .rsp_data_o(z_rdata),
        .count_o(z_cnt), .done_o(z_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (z_iss === 1'b1) z_iss_cnt++;
    end

    // ---------------- reference model (long-run instance) ----------------
    typedef struct {
        int due;
        bit id;
    } rsp_t;

    int         cyc;
    int         md_cnt;
    bit         md_last;
    bit         md_en_prev;
    bit         md_iss;
    logic [7:0] md_a, md_b, md_data;
    rsp_t       md_q[$];

    bit         e_rdy0, e_rdy1, e_iss, e_rsp0, e_rsp1, e_g, e_xfer;
    logic [7:0] e_a, e_b, e_data;
    int         e_cnt;

    // Expectations for the current cycle from the inputs now applied.
    task automatic model_eval();
        bit run_ok;
        bit due;
        run_ok = md_en_prev && en && (md_cnt < M_LEN);
        if (v0 && v1) e_g = ~md_last;
        else          e_g = v1;
        e_rdy0 = run_ok && v0 && !e_g;
        e_rdy1 = run_ok && v1 && e_g;
        e_xfer = e_rdy0 || e_rdy1;
        e_iss  = md_iss;
        e_a    = md_a;
        e_b    = md_b;
        e_cnt  = md_cnt;
        due    = (md_q.size() > 0) && (md_q[0].due == cyc);
        e_rsp0 = due && !md_q[0].id;
        e_rsp1 = due && md_q[0].id;
        e_data = due ? res : md_data;
    endtask

    // Fold this cycle's events into the model at the clock edge.
    task automatic model_commit();
        if (!rst_n) begin
            md_cnt = 0; md_last = 1'b1; md_en_prev = 1'b0; md_iss = 1'b0;
            md_a = '0; md_b = '0; md_data = '0;
            md_q.delete();
        end else begin
            if (e_rsp0 || e_rsp1) begin
                md_data = res;
                void'(md_q.pop_front());
            end
            md_iss = e_xfer;
            if (e_xfer) begin
                md_a = e_g ? a1 : a0;
                md_b = e_g ? b1 : b0;
                md_cnt++;
                md_last = e_g;
                md_q.push_back('{cyc + 1 + M_LAT, e_g});
            end
            md_en_prev = en;
        end
        cyc++;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit e, input bit vv0, input logic [7:0] aa0, input logic [7:0] bb0,
                         input bit vv1, input logic [7:0] aa1, input logic [7:0] bb1);
        en = e; v0 = vv0; a0 = aa0; b0 = bb0; v1 = vv1; a1 = aa1; b1 = bb1;
        res = 8'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        settle();
        advance();
        rst_n = 1'b1;
    endtask

    task automatic enable_cycle();
        drive(1, 0, 0, 0, 0, 0, 0);
        settle();
        advance();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 8'h5a, 8'ha5, 1, 8'h3c, 8'hc3);
        settle();
        advance();
        settle();
        n_chk++; if (m_iss !== 1'b0) begin n_fail++; $display("FAIL reset_issue got=%b exp=0", m_iss); end
        n_chk++; if (m_a_s !== 8'h00 || m_b_s !== 8'h00) begin n_fail++; $display("FAIL reset_ab got=%h/%h exp=00/00", m_a_s, m_b_s); end
        n_chk++; if (m_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", m_cnt); end
        n_chk++; if (m_rdy0 !== 1'b0 || m_rdy1 !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b%b exp=00", m_rdy0, m_rdy1); end
        n_chk++; if (m_rsp0 !== 1'b0 || m_rsp1 !== 1'b0 || m_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsp got=%b%b/%h exp=00/00", m_rsp0, m_rsp1, m_rdata); end
        n_chk++; if (m_done !== 1'b0 || l_done !== 1'b0 || z_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b%b%b exp=000", m_done, l_done, z_done); end
        n_chk++; if (l_cnt !== 8'd0 || z_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_count_other got=%0d/%0d exp=0/0", l_cnt, z_cnt); end
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int xf = 0, n_iss = 0, n_rsp0 = 0;
        do_reset();
        enable_cycle();
        for (int i = 0; i < 12; i++) begin
            drive(1, xf < 3, 8'd1, 8'd2, 0, 0, 0);
            settle();
            n_chk++; if (m_rdy0 !== e_rdy0) begin n_fail++; $display("FAIL single_ready cyc=%0d got=%b exp=%b", i, m_rdy0, e_rdy0); end
            n_chk++; if (m_rsp0 !== e_rsp0 || m_rsp1 !== 1'b0) begin n_fail++; $display("FAIL single_rsp cyc=%0d got=%b%b exp=0%b", i, m_rsp1, m_rsp0, e_rsp0); end
            if (m_iss === 1'b1) begin
                n_iss++;
                n_chk++; if (m_a_s !== 8'd1 || m_b_s !== 8'd2) begin n_fail++; $display("FAIL single_ab got=%0d/%0d exp=1/2", m_a_s, m_b_s); end
            end
            if (m_rsp0 === 1'b1) n_rsp0++;
            if (e_xfer) xf++;
            advance();
        end
        settle();
        n_chk++; if (n_iss != 3) begin n_fail++; $display("FAIL single_issues got=%0d exp=3", n_iss); end
        n_chk++; if (n_rsp0 != 3) begin n_fail++; $display("FAIL single_rsps got=%0d exp=3", n_rsp0); end
        n_chk++; if (m_cnt !== 16'd3) begin n_fail++; $display("FAIL single_count got=%0d exp=3", m_cnt); end
    endtask

    task automatic test_contention();
        int got[$];
        int rq[$];
        do_reset();
        enable_cycle();
        for (int i = 0; i < 14; i++) begin
            drive(1, i < 8, 8'($urandom), 8'($urandom), i < 8, 8'($urandom), 8'($urandom));
            settle();
            n_chk++; if (m_rdy0 !== e_rdy0 || m_rdy1 !== e_rdy1) begin n_fail++; $display("FAIL cont_ready cyc=%0d got=%b%b exp=%b%b", i, m_rdy1, m_rdy0, e_rdy1, e_rdy0); end
            if (m_rdy0 === 1'b1) got.push_back(0);
            else if (m_rdy1 === 1'b1) got.push_back(1);
            if (m_rsp0 === 1'b1) rq.push_back(0);
            if (m_rsp1 === 1'b1) rq.push_back(1);
            advance();
        end
        n_chk++; if (got.size() != 8) begin n_fail++; $display("FAIL cont_grants got=%0d exp=8", got.size()); end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_chk++; if (got[i] != i % 2) begin n_fail++; $display("FAIL cont_order idx=%0d got=%0d exp=%0d", i, got[i], i % 2); end
        end
        n_chk++; if (rq.size() != 8) begin n_fail++; $display("FAIL cont_rsps got=%0d exp=8", rq.size()); end
        for (int i = 0; i < rq.size() && i < 8; i++) begin
            n_chk++; if (rq[i] != i % 2) begin n_fail++; $display("FAIL cont_rsp_id idx=%0d got=%0d exp=%0d", i, rq[i], i % 2); end
        end
    endtask

    task automatic test_limit();
        int nx = 0, nr = 0, early = 0;
        do_reset();
        enable_cycle();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 8'($urandom), 8'($urandom), 1, 8'($urandom), 8'($urandom));
            settle();
            if (l_rdy0 === 1'b1 || l_rdy1 === 1'b1) nx++;
            if (l_rsp0 === 1'b1 || l_rsp1 === 1'b1) nr++;
            if (l_done === 1'b1 && nr < 4) early++;
            advance();
        end
        settle();
        n_chk++; if (nx != 4) begin n_fail++; $display("FAIL limit_xfers got=%0d exp=4", nx); end
        n_chk++; if (l_cnt !== 8'd4) begin n_fail++; $display("FAIL limit_count got=%0d exp=4", l_cnt); end
        n_chk++; if (l_rdy0 !== 1'b0 || l_rdy1 !== 1'b0) begin n_fail++; $display("FAIL limit_ready got=%b%b exp=00", l_rdy1, l_rdy0); end
        n_chk++; if (nr != 4) begin n_fail++; $display("FAIL limit_rsps got=%0d exp=4", nr); end
        n_chk++; if (early != 0) begin n_fail++; $display("FAIL limit_done_early got=%0d exp=0", early); end
        n_chk++; if (l_done !== 1'b1) begin n_fail++; $display("FAIL limit_done got=%b exp=1", l_done); end
    endtask

    task automatic test_pause();
        int xf = 0, iss_b = 0, nr = 0, guard = 0;
        do_reset();
        enable_cycle();
        while (xf < 2 && guard < 10) begin
            drive(1, 1, 8'($urandom), 8'($urandom), 0, 0, 0);
            settle();
            n_chk++; if (m_rdy0 !== e_rdy0) begin n_fail++; $display("FAIL pause_ready_a got=%b exp=%b", m_rdy0, e_rdy0); end
            if (m_rdy0 === 1'b1) xf++;
            if (m_rsp0 === 1'b1) nr++;
            guard++;
            advance();
        end
        n_chk++; if (xf != 2) begin n_fail++; $display("FAIL pause_xfers got=%0d exp=2", xf); end
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 8'($urandom), 8'($urandom), 0, 0, 0);
            settle();
            n_chk++; if (m_rdy0 !== 1'b0) begin n_fail++; $display("FAIL pause_ready_b cyc=%0d got=%b exp=0", i, m_rdy0); end
            if (m_iss === 1'b1) iss_b++;
            if (m_rsp0 === 1'b1) nr++;
            advance();
        end
        settle();
        n_chk++; if (iss_b != 1) begin n_fail++; $display("FAIL pause_issues got=%0d exp=1", iss_b); end
        n_chk++; if (nr != 2) begin n_fail++; $display("FAIL pause_rsps got=%0d exp=2", nr); end
        n_chk++; if (m_cnt !== 16'd2) begin n_fail++; $display("FAIL pause_count got=%0d exp=2", m_cnt); end
        guard = 0;
        xf = 0;
        while (xf < 1 && guard < 6) begin
            drive(1, 1, 8'($urandom), 8'($urandom), 0, 0, 0);
            settle();
            if (m_rdy0 === 1'b1) xf++;
            guard++;
            advance();
        end
        settle();
        n_chk++; if (m_cnt !== 16'd3) begin n_fail++; $display("FAIL resume_count got=%0d exp=3", m_cnt); end
    endtask

    task automatic test_reset_midflight();
        int nr = 0;
        do_reset();
        enable_cycle();
        drive(1, 0, 0, 0, 1, 8'h77, 8'h88);
        settle();
        n_chk++; if (m_rdy1 !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%b exp=1", m_rdy1); end
        advance();
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        settle();
        n_chk++; if (m_iss !== 1'b1) begin n_fail++; $display("FAIL mid_issue got=%b exp=1", m_iss); end
        advance();
        rst_n = 1'b1;
        settle();
        n_chk++; if (m_iss !== 1'b0 || m_a_s !== 8'h00 || m_b_s !== 8'h00) begin n_fail++; $display("FAIL mid_zero_ab got=%b/%h/%h exp=0/00/00", m_iss, m_a_s, m_b_s); end
        n_chk++; if (m_cnt !== 16'd0 || m_done !== 1'b0 || m_rdata !== 8'h00) begin n_fail++; $display("FAIL mid_zero_cnt got=%0d/%b/%h exp=0/0/00", m_cnt, m_done, m_rdata); end
        for (int i = 0; i < M_LAT + 3; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0);
            settle();
            if (m_rsp0 === 1'b1 || m_rsp1 === 1'b1) nr++;
            advance();
        end
        n_chk++; if (nr != 0) begin n_fail++; $display("FAIL mid_stale_rsp got=%0d exp=0", nr); end
        drive(1, 1, 8'($urandom), 8'($urandom), 1, 8'($urandom), 8'($urandom));
        settle();
        n_chk++; if (m_rdy0 !== 1'b1 || m_rdy1 !== 1'b0) begin n_fail++; $display("FAIL mid_first_grant got=%b%b exp=01", m_rdy1, m_rdy0); end
        advance();
    endtask

    task automatic test_zero();
        do_reset();
        drive(1, 1, 8'h11, 8'h22, 1, 8'h33, 8'h44);
        settle();
        n_chk++; if (z_done !== 1'b0) begin n_fail++; $display("FAIL zero_done_early got=%b exp=0", z_done); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 8'h11, 8'h22, 1, 8'h33, 8'h44);
            settle();
            n_chk++; if (z_rdy0 !== 1'b0 || z_rdy1 !== 1'b0) begin n_fail++; $display("FAIL zero_ready got=%b%b exp=00", z_rdy1, z_rdy0); end
            advance();
        end
        settle();
        n_chk++; if (z_done !== 1'b1) begin n_fail++; $display("FAIL zero_done got=%b exp=1", z_done); end
        n_chk++; if (z_cnt !== 4'd0) begin n_fail++; $display("FAIL zero_count got=%0d exp=0", z_cnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rst_n = (($urandom % 100) != 0);
            drive(($urandom % 8) != 0, ($urandom % 3) != 0, 8'($urandom), 8'($urandom),
                  ($urandom % 3) != 0, 8'($urandom), 8'($urandom));
            settle();
            n_chk++; if (m_rdy0 !== e_rdy0) begin n_fail++; $display("FAIL rand_rdy0 cyc=%0d got=%b exp=%b", cyc, m_rdy0, e_rdy0); end
            n_chk++; if (m_rdy1 !== e_rdy1) begin n_fail++; $display("FAIL rand_rdy1 cyc=%0d got=%b exp=%b", cyc, m_rdy1, e_rdy1); end
            n_chk++; if (m_iss !== e_iss) begin n_fail++; $display("FAIL rand_issue cyc=%0d got=%b exp=%b", cyc, m_iss, e_iss); end
            n_chk++; if (m_a_s !== e_a) begin n_fail++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", cyc, m_a_s, e_a); end
            n_chk++; if (m_b_s !== e_b) begin n_fail++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", cyc, m_b_s, e_b); end
            n_chk++; if (m_rsp0 !== e_rsp0) begin n_fail++; $display("FAIL rand_rsp0 cyc=%0d got=%b exp=%b", cyc, m_rsp0, e_rsp0); end
            n_chk++; if (m_rsp1 !== e_rsp1) begin n_fail++; $display("FAIL rand_rsp1 cyc=%0d got=%b exp=%b", cyc, m_rsp1, e_rsp1); end
            n_chk++; if (m_rdata !== e_data) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, m_rdata, e_data); end
            n_chk++; if (m_cnt !== 16'(e_cnt)) begin n_fail++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, m_cnt, e_cnt); end
            n_chk++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL rand_done cyc=%0d got=%b exp=0", cyc, m_done); end
            advance();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        z_iss_cnt = 0;
        cyc = 0;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        model_eval();
        advance();
        test_reset();
        test_single();
        test_contention();
        test_limit();
        test_pause();
        test_reset_midflight();
        test_zero();
        test_random();
        n_chk++; if (z_iss_cnt != 0) begin n_fail++; $display("FAIL zero_issue_seen got=%0d exp=0", z_iss_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bfm_rr_sched.md
BFM_RR_SCHED -- requirements
Module: bfm_rr_sched

Interface
REQ-001 The module SHALL have a parameter LENGTH, default 2000: the total number of operand transfers before the run completes.
REQ-002 The module SHALL have a parameter RES_LAT, default 1, legal range 1-8: the cycles from issue_o high to a valid res_i.
REQ-003 The module SHALL have a parameter CNT_W, default 16: the width of the transfer counter.
REQ-004 The module SHALL use one clock; reset is synchronous and active-low.
REQ-005 The module SHALL have these ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- enable_i  in  1  run enable.
- req0_valid_i  in  1  requester 0 operand valid.
- req0_a_i  in  8  requester 0 operand A.
- req0_b_i  in  8  requester 0 operand B.
- req0_ready_o  out  1  requester 0 accept.
- req1_valid_i, req1_a_i, req1_b_i, req1_ready_o  same as requester 0, for requester 1.
- A_s  out  8  operand A to the bfm.
- B_s  out  8  operand B to the bfm.
- issue_o  out  1  A_s/B_s carry a new operation this cycle.
- res_i  in  8  bfm result.
- rsp0_valid_o  out  1  rsp_data_o belongs to requester 0.
- rsp1_valid_o  out  1  rsp_data_o belongs to requester 1.
- rsp_data_o  out  8  returned result.
- count_o  out  CNT_W  transfers accepted so far.
- done_o  out  1  run complete.

Function
REQ-006 The module SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-007 The state machine SHALL make these transitions:
- IDLE -> RUN when enable_i=1.
- RUN -> IDLE when enable_i=0.
- RUN -> DRAIN when count_o >= LENGTH.
- DRAIN -> DONE when the tag pipeline is empty.
- DONE is held until reset.
REQ-008 reqN_ready_o SHALL be combinational and high only when all of the following hold: state is RUN, enable_i=1, count_o < LENGTH, and requester N holds the grant.
REQ-009 A transfer SHALL occur on reqN_valid_i & reqN_ready_o, with at most one transfer per cycle.
REQ-010 Arbitration SHALL be round-robin:
- If only one requester is valid, it is granted.
- If both are valid, the requester not served by the last transfer is granted.
- The last-served pointer SHALL update only on a transfer.
- After reset, the pointer SHALL favour req0.
REQ-011 The cycle after a transfer, the module SHALL output the transferred A on A_s and B on B_s, with issue_o=1 for exactly one cycle.
REQ-012 In cycles without a transfer, A_s and B_s SHALL hold their values and issue_o SHALL be 0.
REQ-013 count_o SHALL increment by 1 per transfer, saturate at LENGTH, and never wrap.
REQ-014 A tag pipeline of depth RES_LAT SHALL record {valid, requester id} for each issue.
REQ-015 RES_LAT cycles after issue_o, the module SHALL assert the matching rspN_valid_o for one cycle with rsp_data_o = res_i.
REQ-016 The tag pipeline SHALL advance in every state, so responses in flight are delivered after enable_i drops or the run enters DRAIN.
REQ-017 rsp_data_o SHALL hold its last value when no response is valid; rsp0_valid_o and rsp1_valid_o SHALL never both be 1.
REQ-018 Dropping enable_i in RUN SHALL stop new transfers from the same cycle; re-enabling SHALL resume with count_o and the pointer preserved.
REQ-019 With LENGTH=0, enable_i SHALL take the module IDLE -> RUN -> DRAIN -> DONE with no transfers.
REQ-020 done_o SHALL be 1 only in DONE.

Reset
REQ-021 While reset_n_i=0 at a clock edge, the following SHALL hold on the next cycle:
- State is IDLE.
- All outputs are 0, including A_s, B_s, count_o and done_o.
- The tag pipeline is cleared.
- The pointer favours req0.
REQ-022 Reset during RUN or DRAIN SHALL discard in-flight responses: no rspN_valid_o for issues made before reset.

Verification
REQ-023 Single requester: enable=1, req0 valid with a=1, b=2 for 3 cycles -> 3 issue_o pulses with A_s=1, B_s=2; count_o=3; 3 rsp0_valid_o pulses, each RES_LAT cycles after its issue.
REQ-024 Contention: both requesters continuously valid -> grants go 0,1,0,1 starting with req0; rsp ids match the order.
REQ-025 Limit: LENGTH=4, both valid -> exactly 4 transfers; ready outputs 0 afterwards; done_o=1 once the last response is returned (DRAIN emptied).
REQ-026 Pause: enable_i drops after 2 transfers -> no further issue; in-flight response still delivered; re-enable -> count_o continues from 2.
REQ-027 Reset mid-flight: reset_n_i=0 for one cycle right after an issue -> all outputs 0 next cycle; no rsp valid for that issue; after reset, req0 is granted first.
REQ-028 LENGTH=0: enable=1 -> done_o=1 within 3 cycles; issue_o never asserted.
